risc_mc_sequencer: RTL and testbench

- Multi-cycle control sequencer for the 16-bit RISC core; it replaces the single-cycle decode with an FSM.
- Steps the datapath through FETCH, DECODE, EXEC, MEM and WB phases.
- Handshakes with instruction and data memories, each of which may take several cycles.
- Counts retired instructions and traps on an illegal opcode or a memory timeout.

---
 rtl/risc_pkg.sv | 31 +++
 rtl/risc_mc_sequencer_if.sv | 14 +
 rtl/risc_mem_wait_timer.sv | 26 ++
 rtl/risc_mc_sequencer.sv | 153 +++++++++++++++
 tb/tb_risc_mc_sequencer.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/risc_pkg.sv
// Shared definitions for the multi-cycle RISC control sequencer: opcodes,
// ALU operation classes, FSM states and trap cause codes.
package risc_pkg;

    localparam logic [3:0] OP_LD  = 4'b0000;
    localparam logic [3:0] OP_ST  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SLT = 4'b1001;
    localparam logic [3:0] OP_BEQ = 4'b1011;
    localparam logic [3:0] OP_BNE = 4'b1100;
    localparam logic [3:0] OP_JMP = 4'b1101;

    localparam logic [1:0] ALU_OP_ADD = 2'b00;
    localparam logic [1:0] ALU_OP_BR  = 2'b01;
    localparam logic [1:0] ALU_OP_MEM = 2'b10;

    localparam logic [1:0] TRAP_NONE    = 2'b00;
    localparam logic [1:0] TRAP_ILLEGAL = 2'b01;
    localparam logic [1:0] TRAP_IMEM    = 2'b10;
    localparam logic [1:0] TRAP_DMEM    = 2'b11;

    typedef enum logic [2:0] {
        IDLE, FETCH, DECODE, EXEC, MEM, WB, TRAP
    } state_t;

    // 1010, 1110 and 1111 have no instruction assigned.
    function automatic logic is_illegal(input logic [3:0] op);
        return (op == 4'b1010) || (op == 4'b1110) || (op == 4'b1111);
    endfunction

endpackage

// File: rtl/risc_mc_sequencer_if.sv
// Instruction and data memory handshake between the sequencer and memories.
interface risc_mc_sequencer_if;
    // A request is held high until the cycle its ack is seen; the access
    // completes on the cycle where req and ack are both high. Acks seen while
    // the matching req is low carry no meaning and are ignored.
    logic imem_req;
    logic imem_ack;
    logic dmem_req;
    logic dmem_we;
    logic dmem_ack;

    modport master (output imem_req, dmem_req, dmem_we, input imem_ack, dmem_ack);
    modport slave  (input imem_req, dmem_req, dmem_we, output imem_ack, dmem_ack);
endinterface

// File: rtl/risc_mem_wait_timer.sv
// Counts cycles spent waiting for a memory ack; flags the cycle on which one
// more unanswered cycle would reach the limit.
module risc_mem_wait_timer #(
    parameter int TMO_CYC = 15,
    parameter int TMO_W   = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);
    logic [TMO_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + TMO_W'(1);
        end
    end

    assign expired = (cnt == TMO_W'(TMO_CYC - 1));
endmodule

// File: rtl/risc_mc_sequencer.sv
// Multi-cycle control FSM: FETCH/DECODE/EXEC/MEM/WB with memory handshakes,
// retired-instruction counter and sticky traps.
module risc_mc_sequencer
    import risc_pkg::*;
#(
    parameter int CNT_W   = 16,
    parameter int TMO_CYC = 15,
    parameter int TMO_W   = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    risc_mc_sequencer_if.master mem,
    input  logic [3:0]          opcode,
    input  logic                zero,
    output logic                ir_write,
    output logic                pc_inc,
    output logic                pc_write,
    output logic                alu_src,
    output logic [1:0]          alu_op,
    output logic                reg_dst,
    output logic                mem_to_reg,
    output logic                reg_write,
    output logic                busy,
    output logic                trap,
    output logic [1:0]          trap_cause,
    output logic [CNT_W-1:0]    retired,
    output state_t              dbg_state
);
    state_t     state, state_n;
    logic [3:0] op_q;
    logic [1:0] cause_n;
    logic       op_load, retire, tmr_clr, tmr_en, tmr_expired;

    risc_mem_wait_timer #(.TMO_CYC(TMO_CYC), .TMO_W(TMO_W)) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (tmr_clr),
        .en      (tmr_en),
        .expired (tmr_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            op_q       <= '0;
            trap_cause <= TRAP_NONE;
            retired    <= '0;
        end else begin
            state      <= state_n;
            trap_cause <= cause_n;
            if (op_load) op_q <= opcode;
            if (retire) retired <= retired + CNT_W'(1);
        end
    end

    // Strobes tied to a handshake (ir_write, pc_inc) or to the branch flag
    // (pc_write) are qualified by that input inside their state so the
    // zero-wait latencies need no extra states.
    always_comb begin
        state_n      = state;
        cause_n      = trap_cause;
        op_load      = 1'b0;
        retire       = 1'b0;
        tmr_clr      = 1'b1;
        tmr_en       = 1'b0;
        mem.imem_req = 1'b0;
        mem.dmem_req = 1'b0;
        mem.dmem_we  = 1'b0;
        ir_write     = 1'b0;
        pc_inc       = 1'b0;
        pc_write     = 1'b0;
        alu_src      = 1'b0;
        alu_op       = ALU_OP_ADD;
        reg_dst      = 1'b0;
        mem_to_reg   = 1'b0;
        reg_write    = 1'b0;
        case (state)
            IDLE: state_n = FETCH;
            FETCH: begin
                mem.imem_req = 1'b1;
                tmr_clr      = 1'b0;
                if (mem.imem_ack) begin
                    ir_write = 1'b1;
                    pc_inc   = 1'b1;
                    state_n  = DECODE;
                end else if (tmr_expired) begin
                    state_n = TRAP;
                    cause_n = TRAP_IMEM;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            DECODE: begin
                op_load = 1'b1;
                if (is_illegal(opcode)) begin
                    state_n = TRAP;
                    cause_n = TRAP_ILLEGAL;
                end else begin
                    state_n = EXEC;
                end
            end
            EXEC: begin
                if (op_q == OP_LD || op_q == OP_ST) begin
                    alu_op  = ALU_OP_MEM;
                    alu_src = 1'b1;
                    state_n = MEM;
                end else if (op_q == OP_BEQ || op_q == OP_BNE) begin
                    alu_op   = ALU_OP_BR;
                    pc_write = (op_q == OP_BEQ) ? zero : !zero;
                    retire   = 1'b1;
                    state_n  = FETCH;
                end else if (op_q == OP_JMP) begin
                    pc_write = 1'b1;
                    retire   = 1'b1;
                    state_n  = FETCH;
                end else begin
                    state_n = WB;
                end
            end
            MEM: begin
                mem.dmem_req = 1'b1;
                mem.dmem_we  = (op_q == OP_ST);
                tmr_clr      = 1'b0;
                if (mem.dmem_ack) begin
                    if (op_q == OP_LD) begin
                        state_n = WB;
                    end else begin
                        retire  = 1'b1;
                        state_n = FETCH;
                    end
                end else if (tmr_expired) begin
                    state_n = TRAP;
                    cause_n = TRAP_DMEM;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            WB: begin
                reg_write  = 1'b1;
                mem_to_reg = (op_q == OP_LD);
                reg_dst    = (op_q != OP_LD);
                retire     = 1'b1;
                state_n    = FETCH;
            end
            TRAP:    state_n = TRAP;
            default: state_n = IDLE;
        endcase
    end

    assign busy      = (state != IDLE) && (state != TRAP);
    assign trap      = (state == TRAP);
    assign dbg_state = state;
endmodule

// File: tb/tb_risc_mc_sequencer.sv
// Self-checking bench for risc_mc_sequencer: directed and random instructions
// against an instruction-level timing model, plus trap and reset scenarios.
module tb_risc_mc_sequencer;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] opcode = 4'h0;
    logic       zero = 1'b0;
    logic       imem_ack = 1'b0;
    logic       dmem_ack = 1'b0;

    logic        ir_write_a, pc_inc_a, pc_write_a, alu_src_a, reg_dst_a, mem_to_reg_a;
    logic        reg_write_a, busy_a, trap_a;
    logic [1:0]  alu_op_a, trap_cause_a;
    logic [15:0] retired_a;
    logic        ir_write_b, pc_inc_b, pc_write_b, alu_src_b, reg_dst_b, mem_to_reg_b;
    logic        reg_write_b, busy_b, trap_b;
    logic [1:0]  alu_op_b, trap_cause_b;
    logic [3:0]  retired_b;
    risc_pkg::state_t dbg_a, dbg_b;

    int total = 0;
    int bad = 0;
    int model_retired = 0;

    always #5 clk = ~clk;

    risc_mc_sequencer_if mem_a ();
    risc_mc_sequencer_if mem_b ();
    assign mem_a.imem_ack = imem_ack;
    assign mem_a.dmem_ack = dmem_ack;
    assign mem_b.imem_ack = imem_ack;
    assign mem_b.dmem_ack = dmem_ack;

    risc_mc_sequencer dut (
        .clk(clk), .rst_n(rst_n), .mem(mem_a), .opcode(opcode), .zero(zero),
        .ir_write(ir_write_a), .pc_inc(pc_inc_a), .pc_write(pc_write_a),
        .alu_src(alu_src_a), .alu_op(alu_op_a), .reg_dst(reg_dst_a),
        .mem_to_reg(mem_to_reg_a), .reg_write(reg_write_a), .busy(busy_a),
        .trap(trap_a), .trap_cause(trap_cause_a), .retired(retired_a),
        .dbg_state(dbg_a)
    );

    risc_mc_sequencer #(.CNT_W(4)) dut_w4 (
        .clk(clk), .rst_n(rst_n), .mem(mem_b), .opcode(opcode), .zero(zero),
        .ir_write(ir_write_b), .pc_inc(pc_inc_b), .pc_write(pc_write_b),
        .alu_src(alu_src_b), .alu_op(alu_op_b), .reg_dst(reg_dst_b),
        .mem_to_reg(mem_to_reg_b), .reg_write(reg_write_b), .busy(busy_b),
        .trap(trap_b), .trap_cause(trap_cause_b), .retired(retired_b),
        .dbg_state(dbg_b)
    );

    logic [14:0] outs_a;
    assign outs_a = {mem_a.imem_req, mem_a.dmem_req, mem_a.dmem_we, ir_write_a, pc_inc_a,
                     pc_write_a, alu_src_a, alu_op_a, reg_dst_a, mem_to_reg_a, reg_write_a,
                     busy_a, trap_a, trap_cause_a};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        #1;
        check("reset_outs", 32'(outs_a), 32'd0);
        check("reset_retired", 32'(retired_a), 32'd0);
        check("reset_retired_w4", 32'(retired_b), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_retired = 0;
        #1;
        check("idle_busy", 32'(busy_a), 32'd0);
        check("idle_imem_req", 32'(mem_a.imem_req), 32'd0);
    endtask

    // One complete instruction. Memories ack after iw / dw unanswered request
    // cycles; the window length and per-signal pulse counts come from the
    // instruction-level model (FETCH iw+1, DECODE 1, EXEC 1, MEM dw+1, WB 1).
    task automatic run_instr(input logic [3:0] op, input logic z, input int iw, input int dw);
        bit is_ld, is_st, is_r, is_beq, is_bne, is_jmp;
        int fl, len, icnt, dcnt;
        int n_ireq, n_ir, n_pci, n_dreq, n_we, n_pcw, n_rw, n_m2r, n_rd, n_asrc, n_busy, n_trap;
        logic [1:0] exec_aop;
        string nm;
        is_ld  = (op == 4'd0);
        is_st  = (op == 4'd1);
        is_r   = (op >= 4'd2) && (op <= 4'd9);
        is_beq = (op == 4'd11);
        is_bne = (op == 4'd12);
        is_jmp = (op == 4'd13);
        fl  = iw + 1;
        len = is_ld ? fl + dw + 4 : is_st ? fl + dw + 3 : is_r ? fl + 3 : fl + 2;
        {icnt, dcnt, n_ireq, n_ir, n_pci, n_dreq, n_we, n_pcw} = '0;
        {n_rw, n_m2r, n_rd, n_asrc, n_busy, n_trap} = '0;
        exec_aop = 2'bxx;
        nm = $sformatf("op%0d", op);
        opcode = op;
        zero = z;
        for (int k = 0; k < len; k++) begin
            @(negedge clk);
            imem_ack = mem_a.imem_req ? (icnt == iw) : 1'($urandom_range(0, 1));
            dmem_ack = mem_a.dmem_req ? (dcnt == dw) : 1'($urandom_range(0, 1));
            #1;
            if (k == 0) begin
                check({nm, "_retired"}, 32'(retired_a), 32'(model_retired % 65536));
                check({nm, "_retired_w4"}, 32'(retired_b), 32'(model_retired % 16));
            end
            if (k == fl + 1) exec_aop = alu_op_a;
            n_ireq += int'(mem_a.imem_req);
            n_dreq += int'(mem_a.dmem_req);
            n_we   += int'(mem_a.dmem_req && mem_a.dmem_we);
            n_ir   += int'(ir_write_a);
            n_pci  += int'(pc_inc_a);
            n_pcw  += int'(pc_write_a);
            n_rw   += int'(reg_write_a);
            n_m2r  += int'(mem_to_reg_a);
            n_rd   += int'(reg_dst_a);
            n_asrc += int'(alu_src_a);
            n_busy += int'(busy_a);
            n_trap += int'(trap_a);
            if (mem_a.imem_req) icnt++;
            if (mem_a.dmem_req) dcnt++;
        end
        model_retired++;
        check({nm, "_imem_req_cyc"}, 32'(n_ireq), 32'(fl));
        check({nm, "_ir_write"}, 32'(n_ir), 32'd1);
        check({nm, "_pc_inc"}, 32'(n_pci), 32'd1);
        check({nm, "_dmem_req_cyc"}, 32'(n_dreq), 32'((is_ld || is_st) ? dw + 1 : 0));
        check({nm, "_dmem_we_cyc"}, 32'(n_we), 32'(is_st ? dw + 1 : 0));
        check({nm, "_pc_write"}, 32'(n_pcw), 32'((is_beq && z) || (is_bne && !z) || is_jmp));
        check({nm, "_reg_write"}, 32'(n_rw), 32'(is_ld || is_r));
        check({nm, "_mem_to_reg"}, 32'(n_m2r), 32'(is_ld));
        check({nm, "_reg_dst"}, 32'(n_rd), 32'(is_r));
        check({nm, "_alu_src"}, 32'(n_asrc), 32'(is_ld || is_st));
        check({nm, "_alu_op"}, 32'(exec_aop), (is_ld || is_st) ? 32'd2 : (is_beq || is_bne) ? 32'd1 : 32'd0);
        check({nm, "_busy_cyc"}, 32'(n_busy), 32'(len));
        check({nm, "_trap"}, 32'(n_trap), 32'd0);
    endtask

    initial begin
        int n, r;
        logic [3:0] op;

        // Directed instructions with zero-wait and delayed memories.
        do_reset();
        run_instr(4'd2, 1'b0, 0, 0);
        run_instr(4'd0, 1'b0, 0, 3);
        run_instr(4'd11, 1'b1, 0, 0);
        run_instr(4'd12, 1'b1, 0, 0);
        run_instr(4'd1, 1'b0, 0, 0);
        run_instr(4'd0, 1'b1, 2, 0);

        // Random legal instruction stream with random memory latencies.
        for (int i = 0; i < 40; i++) begin
            r = $urandom_range(0, 12);
            op = (r < 10) ? 4'(r) : 4'(r + 1);
            run_instr(op, 1'($urandom_range(0, 1)), $urandom_range(0, 4), $urandom_range(0, 4));
        end

        // Reset asserted while a load waits in MEM.
        opcode = 4'd0;
        n = 0;
        for (int k = 0; k < 20 && n < 2; k++) begin
            @(negedge clk);
            imem_ack = mem_a.imem_req;
            dmem_ack = 1'b0;
            #1;
            n += int'(mem_a.dmem_req);
        end
        check("mid_mem_reached", 32'(n), 32'd2);
        #2 rst_n = 1'b0;
        #1;
        check("mid_mem_dmem_req", 32'(mem_a.dmem_req), 32'd0);
        check("mid_mem_dmem_req_w4", 32'(mem_b.dmem_req), 32'd0);
        check("mid_mem_retired", 32'(retired_a), 32'd0);
        check("mid_mem_retired_w4", 32'(retired_b), 32'd0);
        check("mid_mem_busy", 32'(busy_a), 32'd0);

        // Seventeen jumps: the 4-bit counter wraps through zero.
        do_reset();
        for (int i = 0; i < 17; i++) run_instr(4'd13, 1'($urandom_range(0, 1)), 0, 0);
        @(negedge clk);
        imem_ack = 1'b0;
        #1;
        check("wrap_retired_w4", 32'(retired_b), 32'(model_retired % 16));
        check("wrap_retired", 32'(retired_a), 32'(model_retired));

        // Instruction memory never answers.
        do_reset();
        n = 0;
        for (int k = 0; k < 40 && !trap_a; k++) begin
            @(negedge clk);
            imem_ack = 1'b0;
            #1;
            n += int'(mem_a.imem_req);
        end
        check("itmo_req_cyc", 32'(n), 32'd15);
        check("itmo_trap", 32'(trap_a), 32'd1);
        check("itmo_cause", 32'(trap_cause_a), 32'd2);
        check("itmo_busy", 32'(busy_a), 32'd0);

        // Ack on the very cycle the limit would be reached wins over the trap.
        do_reset();
        run_instr(4'd2, 1'b0, 14, 0);
        run_instr(4'd1, 1'b0, 0, 14);

        // Data memory never answers.
        do_reset();
        opcode = 4'd0;
        n = 0;
        for (int k = 0; k < 40 && !trap_a; k++) begin
            @(negedge clk);
            imem_ack = mem_a.imem_req;
            dmem_ack = 1'b0;
            #1;
            n += int'(mem_a.dmem_req);
        end
        check("dtmo_req_cyc", 32'(n), 32'd15);
        check("dtmo_trap", 32'(trap_a), 32'd1);
        check("dtmo_cause", 32'(trap_cause_a), 32'd3);

        // Illegal opcode traps after DECODE and stays trapped.
        do_reset();
        opcode = 4'hE;
        @(negedge clk);
        imem_ack = 1'b1;
        @(negedge clk);
        imem_ack = 1'b0;
        n = 0;
        r = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            imem_ack = 1'($urandom_range(0, 1));
            dmem_ack = 1'($urandom_range(0, 1));
            #1;
            n += int'(mem_a.imem_req);
            r += int'(trap_a);
        end
        check("ill_trap_cyc", 32'(r), 32'd5);
        check("ill_cause", 32'(trap_cause_a), 32'd1);
        check("ill_busy", 32'(busy_a), 32'd0);
        check("ill_no_fetch", 32'(n), 32'd0);
        check("ill_retired", 32'(retired_a), 32'd0);
        check("ill_ctrl_quiet", 32'(outs_a[14:3]), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        bad++;
        $display("FAIL watchdog observed=timeout expected=finish");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
